instr_fetch_buffer: RTL and testbench

INSTR_FETCH_BUFFER -- requirements
Module: instr_fetch_buffer

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/instr_fetch_buffer_fifo.sv | 58 +++++
 rtl/instr_fetch_buffer.sv | 120 ++++++++++++
 tb/tb_instr_fetch_buffer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types: buffered entry layout, fetch FSM states, default FIFO depth.
package fetch_pkg;

  localparam int unsigned FETCH_DW            = 32;
  localparam int unsigned FETCH_DEPTH_DEFAULT = 4;

  // One fetched instruction with its address and fall-through address
  typedef struct packed {
    logic [FETCH_DW-1:0] instr;
    logic [FETCH_DW-1:0] pc;
    logic [FETCH_DW-1:0] pcplus4;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // Fall-through address, wrapping at the top of the address space
  function automatic logic [FETCH_DW-1:0] pc_plus4(input logic [FETCH_DW-1:0] a);
    return FETCH_DW'(a + FETCH_DW'(4));
  endfunction

endpackage

// File: rtl/instr_fetch_buffer_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush; flush beats push/pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: single-outstanding instruction fetcher feeding decode via a FIFO.
// Optional macro FETCH_BYPASS_EN: an ack into an empty buffer is shown to decode in the
// same cycle, and is not stored if decode takes it immediately.
// Entries are FETCH_DW wide; DATA_WIDTH is expected to equal FETCH_DW.
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = FETCH_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  redirect,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  pc_advance,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_pcplus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t          state;
  logic [DATA_WIDTH-1:0] cap_pc;

  fetch_entry_t          new_entry;
  fetch_entry_t          head;
  fetch_entry_t          shown;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  take;
  logic                  push;
  logic                  pop;

  // An ack is accepted only for a live request that is not being redirected away
  assign take       = !rst && (state == BUSY) && imem_ack && !redirect;
  assign pc_advance = take;
  assign pop        = !fifo_empty && id_ready;

  // Entry built from the returning word and the address captured at issue
  always_comb begin
    new_entry         = '0;
    new_entry.instr   = FETCH_DW'(imem_rdata);
    new_entry.pc      = FETCH_DW'(cap_pc);
    new_entry.pcplus4 = pc_plus4(FETCH_DW'(cap_pc));
  end

`ifdef FETCH_BYPASS_EN
  logic bypass;

  // Empty buffer: forward the ack straight to decode, store only if decode stalls
  assign bypass   = take && fifo_empty;
  assign push     = take && !(bypass && id_ready);
  assign id_valid = !fifo_empty || bypass;
  assign shown    = bypass ? new_entry : head;
`else
  // Every accepted ack goes through the buffer first
  assign push     = take;
  assign id_valid = !fifo_empty;
  assign shown    = head;
`endif

  assign id_instr   = DATA_WIDTH'(shown.instr);
  assign id_pc      = DATA_WIDTH'(shown.pc);
  assign id_pcplus4 = DATA_WIDTH'(shown.pcplus4);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push && !fifo_full),
    .pop   (pop),
    .flush (redirect),
    .din   (new_entry),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Request FSM: issue only with a free slot, so buffered + outstanding never exceeds DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      cap_pc    <= '0;
    end else begin
      imem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (!redirect && (fifo_count < CW'(DEPTH))) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
            cap_pc    <= pc;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (imem_ack)      state <= IDLE;
          else if (redirect) state <= DISCARD;
        end
        DISCARD: begin
          // The stale ack ends the discard even if another redirect lands with it
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed vector table, hand-built corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_instr_fetch_buffer;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam bit NB    = !BYP;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        redirect = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        pc_advance;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pcplus4;

  instr_fetch_buffer #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .redirect(redirect),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc_advance(pc_advance), .id_valid(id_valid),
    .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pcplus4(id_pcplus4)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          r, rd, a, rdy;
    logic [31:0] p, rdat;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_adv, e_valid;
    logic [31:0] e_instr, e_pc, e_p4;
  } vec_t;

  function automatic vec_t mk(bit r, bit rd, bit a, bit rdy, logic [31:0] p, logic [31:0] rdat,
                              bit er, logic [31:0] ea, bit eadv, bit ev,
                              logic [31:0] ei, logic [31:0] ep, logic [31:0] ep4);
    vec_t v;
    v.r = r; v.rd = rd; v.a = a; v.rdy = rdy; v.p = p; v.rdat = rdat;
    v.e_req = er; v.e_addr = ea; v.e_adv = eadv; v.e_valid = ev;
    v.e_instr = ei; v.e_pc = ep; v.e_p4 = ep4;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr, pc, p4;
  } ent_t;

  ent_t        q[$];
  int          m_out = 0;        // 0 nothing outstanding, 1 live request, 2 request to drop
  bit          m_req = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_cap = '0;
  logic [31:0] cur_pc = '0;
  bit          pend = 0;
  int          cnt = 0;
  int          lat_fixed = 0;
  bit          ack_force = 0;
  bit          chk_en = 1;
  int          req_seen = 0;

  task automatic step(input bit r, input bit redir, input bit rdy, input logic [31:0] tgt);
    logic [31:0] rdat;
    bit a, e_req, e_adv, byp, e_valid, issue, popq, pushq;
    ent_t e_ent, n_ent;
    int qs;
    @(negedge clk);
    a    = ack_force || (pend && cnt == 0);
    rdat = $urandom;
    if (redir) cur_pc = tgt;
    rst = r; redirect = redir; id_ready = rdy; imem_ack = a; imem_rdata = rdat; pc = cur_pc;
    #1;
    if (imem_req) req_seen++;
    qs      = q.size();
    e_req   = m_req;
    n_ent   = '{rdat, m_cap, m_cap + 32'd4};
    e_adv   = !r && m_out == 1 && a && !redir;
    byp     = BYP && e_adv && qs == 0;
    e_valid = (qs > 0) || byp;
    e_ent   = (qs > 0) ? q[0] : n_ent;
    if (chk_en) begin
      chk("imem_req", 32'(imem_req), 32'(e_req));
      chk("imem_addr", imem_addr, m_addr);
      chk("pc_advance", 32'(pc_advance), 32'(e_adv));
      chk("id_valid", 32'(id_valid), 32'(e_valid));
      if (e_valid && id_valid) begin
        chk("id_instr", id_instr, e_ent.instr);
        chk("id_pc", id_pc, e_ent.pc);
        chk("id_pcplus4", id_pcplus4, e_ent.p4);
      end
    end
    if (r) begin
      q.delete(); m_out = 0; m_req = 0; m_addr = '0; m_cap = '0; pend = 0;
    end else begin
      issue = (m_out == 0) && !redir && (qs < DEPTH);
      popq  = (qs > 0) && rdy;
      pushq = e_adv && !(byp && rdy);
      if (redir) q.delete();
      else begin
        if (popq) void'(q.pop_front());
        if (pushq) q.push_back(n_ent);
      end
      case (m_out)
        0: if (issue) begin m_out = 1; m_addr = pc; m_cap = pc; end
        1: if (a) m_out = 0; else if (redir) m_out = 2;
        default: if (a) m_out = 0;
      endcase
      m_req = issue;
      if (pend) begin
        if (cnt == 0) pend = 0; else cnt--;
      end
      if (e_req) begin
        pend = 1;
        cnt  = (lat_fixed > 0 ? lat_fixed : int'($urandom_range(1, 3))) - 1;
      end
      if (e_adv) cur_pc = cur_pc + 32'd4;
    end
    ack_force = 0;
  endtask

  task automatic model_reset();
    chk_en = 0;
    step(1, 0, 0, '0);
    chk_en = 1;
    step(1, 0, 0, '0);
    cur_pc = '0;
  endtask

  vec_t tbl[17];
  bit   found;
  logic [31:0] tgt;

  initial begin
    tbl[0]  = mk(1,0,0,0, 32'h0,        32'h0,        0,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(0,0,0,0, 32'h0,        32'h0,        0,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[2]  = mk(0,0,0,0, 32'h0,        32'h0,        1,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[3]  = mk(0,0,1,0, 32'h0,        32'h00500093, 0,32'h0,        1,BYP,32'h00500093, 32'h0,        32'h4);
    tbl[4]  = mk(0,0,0,0, 32'hFFFFFFFC, 32'h0,        0,32'h0,        0,1,  32'h00500093, 32'h0,        32'h4);
    tbl[5]  = mk(0,0,0,1, 32'hFFFFFFFC, 32'h0,        1,32'hFFFFFFFC, 0,1,  32'h00500093, 32'h0,        32'h4);
    tbl[6]  = mk(0,0,1,1, 32'hFFFFFFFC, 32'h00A00113, 0,32'hFFFFFFFC, 1,BYP,32'h00A00113, 32'hFFFFFFFC, 32'h0);
    tbl[7]  = mk(0,0,0,0, 32'h0,        32'h0,        0,32'hFFFFFFFC, 0,NB, 32'h00A00113, 32'hFFFFFFFC, 32'h0);
    tbl[8]  = mk(0,0,0,1, 32'h0,        32'h0,        1,32'h0,        0,NB, 32'h00A00113, 32'hFFFFFFFC, 32'h0);
    tbl[9]  = mk(0,0,0,1, 32'h0,        32'h0,        0,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[10] = mk(0,1,0,1, 32'h100,      32'h0,        0,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[11] = mk(0,0,0,1, 32'h100,      32'h0,        0,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[12] = mk(0,0,1,1, 32'h100,      32'hDEADBEEF, 0,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[13] = mk(0,0,0,1, 32'h100,      32'h0,        0,32'h0,        0,0,  32'h0,        32'h0,        32'h0);
    tbl[14] = mk(0,0,0,0, 32'h100,      32'h0,        1,32'h100,      0,0,  32'h0,        32'h0,        32'h0);
    tbl[15] = mk(0,0,1,0, 32'h100,      32'h13,       0,32'h100,      1,BYP,32'h13,       32'h100,      32'h104);
    tbl[16] = mk(0,0,0,0, 32'h104,      32'h0,        0,32'h100,      0,1,  32'h13,       32'h100,      32'h104);

    // Directed table: reset, first fetch, wrap of pc+4, bypass timing, redirect/discard
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = tbl[i].r; redirect = tbl[i].rd; imem_ack = tbl[i].a; id_ready = tbl[i].rdy;
      pc = tbl[i].p; imem_rdata = tbl[i].rdat;
      #1;
      chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d pc_advance", i), 32'(pc_advance), 32'(tbl[i].e_adv));
      chk($sformatf("vec%0d id_valid", i), 32'(id_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid || tbl[i].r) begin
        chk($sformatf("vec%0d id_instr", i), id_instr, tbl[i].e_instr);
        chk($sformatf("vec%0d id_pc", i), id_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d id_pcplus4", i), id_pcplus4, tbl[i].e_p4);
      end
    end

    // Decode stalled: buffer fills to DEPTH and requests stop
    model_reset();
    lat_fixed = 1;
    req_seen  = 0;
    for (int i = 0; i < 30; i++) step(0, 0, 0, '0);
    chk("full_req_count", 32'(req_seen), 32'(DEPTH));

    // Three entries buffered, then push and pop in the same cycle
    model_reset();
    lat_fixed = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (q.size() == 3 && pend && cnt == 0) begin
        found = 1;
        step(0, 0, 1, '0);
      end else begin
        step(0, 0, 0, '0);
      end
    end
    chk("fill3_reached", 32'(found), 32'd1);
    req_seen = 0;
    for (int i = 0; i < 15; i++) step(0, 0, 0, '0);
    chk("refill_req_count", 32'(req_seen), 32'd1);

    // Reset while a request is outstanding; the late ack must be ignored
    model_reset();
    lat_fixed = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out == 1 && pend) found = 1;
      else step(0, 0, 1, '0);
    end
    chk("outstanding_reached", 32'(found), 32'd1);
    step(1, 0, 1, '0);
    ack_force = 1;
    step(0, 0, 1, '0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, '0);

    // Redirect with a partly full buffer flushes it
    lat_fixed = 1;
    for (int i = 0; i < 8; i++) step(0, 0, 0, '0);
    step(0, 1, 0, 32'h200);
    for (int i = 0; i < 8; i++) step(0, 0, 1, '0);

    // Randomized traffic
    model_reset();
    lat_fixed = 0;
    for (int i = 0; i < 1500; i++) begin
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFFFFF8;
      if (m_out == 0 && !pend && $urandom_range(0, 9) == 0) ack_force = 1;
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0),
           bit'($urandom_range(0, 1)), tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
